// File: rtl/wb_write_queue_if.sv
// wb_write_queue_if
//   Bundles the signals between the writeback/decode side of the pipeline and
//   the write queue that feeds the 8x16 register file.
//   master : pipeline side (offers results, controls hold/flush, looks up fwd_num)
//   slave  : queue side (accepts results, drives the register-file write port,
//            the busy scoreboard, the forwarding result and the fill level)
//   Signals:
//     in_valid/in_ready/in_reg/in_data : writeback result handshake
//     hold, flush                      : drain suppression / discard of all entries
//     write/writenum/data_in           : register-file write port
//     busy                             : one bit per register with a queued write
//     fwd_num/fwd_hit/fwd_data         : youngest-match forwarding lookup
//     count                            : number of valid entries
interface wb_write_queue_if #(
    parameter int DEPTH = 4,
    parameter int DW    = 16,
    parameter int AW    = 3
);
    localparam int CW = $clog2(DEPTH) + 1;

    logic              in_valid;
    logic              in_ready;
    logic [AW-1:0]     in_reg;
    logic [DW-1:0]     in_data;
    logic              hold;
    logic              flush;
    logic              write;
    logic [AW-1:0]     writenum;
    logic [DW-1:0]     data_in;
    logic [(1<<AW)-1:0] busy;
    logic [AW-1:0]     fwd_num;
    logic              fwd_hit;
    logic [DW-1:0]     fwd_data;
    logic [CW-1:0]     count;

    modport master (
        output in_valid, in_reg, in_data, hold, flush, fwd_num,
        input  in_ready, write, writenum, data_in, busy, fwd_hit, fwd_data, count
    );

    modport slave (
        input  in_valid, in_reg, in_data, hold, flush, fwd_num,
        output in_ready, write, writenum, data_in, busy, fwd_hit, fwd_data, count
    );
endinterface

// File: rtl/wb_write_queue.sv
// wb_write_queue
//   In-order write buffer between the writeback stage and the single write
//   port of the register file. Results are queued as {reg, data}, drained one
//   per cycle from the head, and the queued contents are exposed as a per-
//   register busy scoreboard plus a youngest-match forwarding lookup.
//   Ports:
//     clk   : rising-edge clock shared with the register file
//     rst_n : asynchronous active-low reset
//     q     : wb_write_queue_if.slave (handshake, drain port, busy, fwd, count)
module wb_write_queue #(
    parameter int DEPTH = 4,
    parameter int DW    = 16,
    parameter int AW    = 3
) (
    input  logic             clk,
    input  logic             rst_n,
    wb_write_queue_if.slave  q
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam int NR = 1 << AW;
    localparam logic [CW-1:0] FULL = CW'(DEPTH);

    // Payload storage: never reset, qualified by the valid bits.
    logic [AW-1:0]    mem_reg  [DEPTH];
    logic [DW-1:0]    mem_data [DEPTH];

    logic [DEPTH-1:0] valid;
    logic [PW-1:0]    rd_ptr;
    logic [PW-1:0]    wr_ptr;
    logic [CW-1:0]    count;

    logic             push;
    logic             pop;

    logic [NR-1:0]    busy_c;
    logic             fwd_hit_c;
    logic [DW-1:0]    fwd_data_c;
    logic [PW-1:0]    fwd_idx;

    // A full queue refuses input even while it drains this cycle; this keeps
    // in_ready independent of hold and of the pop.
    assign q.in_ready = (count != FULL) && !q.flush;
    assign q.write    = (count != '0) && !q.hold && !q.flush;

    assign push = q.in_valid && q.in_ready;
    assign pop  = q.write;

    assign q.writenum = mem_reg[rd_ptr];
    assign q.data_in  = mem_data[rd_ptr];
    assign q.count    = count;
    assign q.busy     = busy_c;
    assign q.fwd_hit  = fwd_hit_c;
    assign q.fwd_data = fwd_data_c;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid  <= '0;
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else if (q.flush) begin
            // push and pop are both blocked while flushing
            valid  <= '0;
            rd_ptr <= wr_ptr;
            count  <= '0;
        end else begin
            // push and pop never hit the same slot: that would need the queue
            // to be both full (push blocked) and empty (pop blocked)
            if (push) begin
                valid[wr_ptr] <= 1'b1;
                wr_ptr        <= wr_ptr + PW'(1);
            end
            if (pop) begin
                valid[rd_ptr] <= 1'b0;
                rd_ptr        <= rd_ptr + PW'(1);
            end
            unique case ({push, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem_reg[wr_ptr]  <= q.in_reg;
            mem_data[wr_ptr] <= q.in_data;
        end
    end

    always_comb begin
        busy_c = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (valid[i]) begin
                busy_c[mem_reg[i]] = 1'b1;
            end
        end
    end

    // Walk the entries oldest to youngest starting at the head; a later match
    // overrides an earlier one so the youngest value is forwarded.
    always_comb begin
        fwd_hit_c  = 1'b0;
        fwd_data_c = '0;
        fwd_idx    = '0;
        for (int k = 0; k < DEPTH; k++) begin
            fwd_idx = rd_ptr + PW'(k);
            if (valid[fwd_idx] && (mem_reg[fwd_idx] == q.fwd_num)) begin
                fwd_hit_c  = 1'b1;
                fwd_data_c = mem_data[fwd_idx];
            end
        end
    end
endmodule

// File: tb/tb_wb_write_queue.sv
// tb_wb_write_queue
//   Directed scenarios plus a randomized run of wb_write_queue against a
//   queue-based reference model and a register-file model.
module tb_wb_write_queue;
    localparam int DEPTH = 4;
    localparam int DW    = 16;
    localparam int AW    = 3;
    localparam int CW    = $clog2(DEPTH) + 1;
    localparam int NR    = 1 << AW;

    typedef struct packed {
        logic [AW-1:0] r;
        logic [DW-1:0] d;
    } ent_t;

    logic clk = 1'b0;
    logic rst_n;

    always #5 clk = ~clk;

    wb_write_queue_if #(.DEPTH(DEPTH), .DW(DW), .AW(AW)) bus ();

    wb_write_queue #(.DEPTH(DEPTH), .DW(DW), .AW(AW)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .q     (bus)
    );

    ent_t          mq[$];
    logic [DW-1:0] rf_ref [NR];
    logic [DW-1:0] rf_dut [NR];
    int            checks = 0;
    int            errors = 0;
    int            dut_wr = 0;
    int            ref_wr = 0;

    // Register file: captures the write port on the rising edge.
    always @(posedge clk) begin
        if (rst_n && bus.write) begin
            rf_dut[bus.writenum] = bus.data_in;
            dut_wr = dut_wr + 1;
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic logic [NR-1:0] exp_busy();
        logic [NR-1:0] b = '0;
        foreach (mq[i]) b[mq[i].r] = 1'b1;
        return b;
    endfunction

    function automatic logic exp_hit(input logic [AW-1:0] n);
        logic h = 1'b0;
        foreach (mq[i]) if (mq[i].r == n) h = 1'b1;
        return h;
    endfunction

    function automatic logic [DW-1:0] exp_fwd(input logic [AW-1:0] n);
        logic [DW-1:0] d = '0;
        foreach (mq[i]) if (mq[i].r == n) d = mq[i].d;
        return d;
    endfunction

    // Apply this cycle's inputs to the model, then take the clock edge.
    task automatic advance();
        logic rdy;
        logic wr;
        ent_t e;
        rdy = (mq.size() != DEPTH) && !bus.flush;
        wr  = (mq.size() != 0) && !bus.hold && !bus.flush;
        e.r = bus.in_reg;
        e.d = bus.in_data;
        if (bus.flush) begin
            mq.delete();
        end else begin
            if (wr) begin
                rf_ref[mq[0].r] = mq[0].d;
                ref_wr++;
                void'(mq.pop_front());
            end
            if (bus.in_valid && rdy) mq.push_back(e);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        bus.in_valid = 1'b0;
        bus.hold     = 1'b0;
        bus.flush    = 1'b0;
    endtask

    task automatic push_now(input logic [AW-1:0] r, input logic [DW-1:0] d);
        bus.in_valid = 1'b1;
        bus.in_reg   = r;
        bus.in_data  = d;
        advance();
        bus.in_valid = 1'b0;
    endtask

    task automatic drain();
        idle();
        for (int i = 0; i < 3 * DEPTH && mq.size() != 0; i++) advance();
        #1;
        checks++;
        if (bus.count !== CW'(0)) begin
            errors++;
            $display("FAIL drain_count actual=%0d required=0", bus.count);
        end
    endtask

    task automatic test_reset();
        idle();
        bus.fwd_num = '0;
        bus.in_reg  = '0;
        bus.in_data = '0;
        rst_n = 1'b1;
        #1 rst_n = 1'b0;
        #1;
        checks++;
        if ({bus.write, bus.busy, bus.count, bus.in_ready, bus.fwd_hit, bus.fwd_data} !==
            {1'b0, NR'(0), CW'(0), 1'b1, 1'b0, DW'(0)}) begin
            errors++;
            $display("FAIL reset_state actual write=%b busy=%h count=%0d in_ready=%b fwd_hit=%b fwd_data=%h required 0 0 0 1 0 0",
                     bus.write, bus.busy, bus.count, bus.in_ready, bus.fwd_hit, bus.fwd_data);
        end
        @(posedge clk);
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk);
        #1;
        // mid-stream reset with 3 entries queued
        bus.hold = 1'b1;
        for (int i = 0; i < 3; i++) push_now(AW'(i + 5), DW'($urandom));
        bus.hold = 1'b0;
        #1;
        checks++;
        if (bus.count !== CW'(3) || bus.write !== 1'b1) begin
            errors++;
            $display("FAIL reset_prefill actual count=%0d write=%b required count=3 write=1", bus.count, bus.write);
        end
        #1 rst_n = 1'b0;
        #1;
        checks++;
        if ({bus.write, bus.busy, bus.count, bus.in_ready} !== {1'b0, NR'(0), CW'(0), 1'b1}) begin
            errors++;
            $display("FAIL reset_async actual write=%b busy=%h count=%0d in_ready=%b required 0 0 0 1",
                     bus.write, bus.busy, bus.count, bus.in_ready);
        end
        mq.delete();
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic test_single_push();
        idle();
        bus.in_valid = 1'b1;
        bus.in_reg   = AW'(3);
        bus.in_data  = 16'h00A5;
        #1;
        checks++;
        if (bus.in_ready !== 1'b1 || bus.write !== 1'b0) begin
            errors++;
            $display("FAIL single_pre actual in_ready=%b write=%b required 1 0", bus.in_ready, bus.write);
        end
        advance();
        bus.in_valid = 1'b0;
        #1;
        checks++;
        if ({bus.write, bus.writenum, bus.data_in, bus.busy, bus.count} !==
            {1'b1, AW'(3), 16'h00A5, NR'(8'h08), CW'(1)}) begin
            errors++;
            $display("FAIL single_present actual write=%b num=%0d data=%h busy=%h count=%0d required 1 3 00a5 08 1",
                     bus.write, bus.writenum, bus.data_in, bus.busy, bus.count);
        end
        advance();
        checks++;
        if (bus.count !== CW'(0) || bus.busy !== NR'(0) || rf_dut[3] !== 16'h00A5) begin
            errors++;
            $display("FAIL single_done actual count=%0d busy=%h R3=%h required 0 00 00a5",
                     bus.count, bus.busy, rf_dut[3]);
        end
    endtask

    task automatic test_fill_hold();
        idle();
        bus.hold = 1'b1;
        for (int i = 1; i <= 4; i++) push_now(AW'(i), DW'(16'h0011 * i));
        checks++;
        if (bus.count !== CW'(4) || bus.in_ready !== 1'b0 || bus.busy !== NR'(8'h1E) || bus.write !== 1'b0) begin
            errors++;
            $display("FAIL fill_full actual count=%0d in_ready=%b busy=%h write=%b required 4 0 1e 0",
                     bus.count, bus.in_ready, bus.busy, bus.write);
        end
        push_now(AW'(5), 16'h0055);
        checks++;
        if (bus.count !== CW'(4) || bus.busy !== NR'(8'h1E)) begin
            errors++;
            $display("FAIL fill_fifth actual count=%0d busy=%h required 4 1e", bus.count, bus.busy);
        end
        bus.hold = 1'b0;
        for (int i = 1; i <= 4; i++) begin
            #1;
            checks++;
            if ({bus.write, bus.writenum, bus.data_in} !== {1'b1, AW'(i), DW'(16'h0011 * i)}) begin
                errors++;
                $display("FAIL fill_order%0d actual write=%b num=%0d data=%h required 1 %0d %h",
                         i, bus.write, bus.writenum, bus.data_in, i, 16'h0011 * i);
            end
            advance();
        end
        checks++;
        if (bus.count !== CW'(0) || rf_dut[4] !== 16'h0044 || rf_dut[1] !== 16'h0011) begin
            errors++;
            $display("FAIL fill_drained actual count=%0d R1=%h R4=%h required 0 0011 0044",
                     bus.count, rf_dut[1], rf_dut[4]);
        end
    endtask

    task automatic test_same_reg_fwd();
        idle();
        bus.hold = 1'b1;
        push_now(AW'(2), 16'h1111);
        push_now(AW'(2), 16'h2222);
        bus.fwd_num = AW'(2);
        #1;
        checks++;
        if (bus.fwd_hit !== 1'b1 || bus.fwd_data !== 16'h2222 || bus.busy !== NR'(8'h04)) begin
            errors++;
            $display("FAIL fwd_youngest actual hit=%b data=%h busy=%h required 1 2222 04",
                     bus.fwd_hit, bus.fwd_data, bus.busy);
        end
        bus.fwd_num = AW'(6);
        #1;
        checks++;
        if (bus.fwd_hit !== 1'b0 || bus.fwd_data !== DW'(0)) begin
            errors++;
            $display("FAIL fwd_miss actual hit=%b data=%h required 0 0000", bus.fwd_hit, bus.fwd_data);
        end
        bus.hold = 1'b0;
        advance();
        advance();
        checks++;
        if (rf_dut[2] !== 16'h2222 || bus.count !== CW'(0)) begin
            errors++;
            $display("FAIL fwd_final actual R2=%h count=%0d required 2222 0", rf_dut[2], bus.count);
        end
    endtask

    task automatic test_full_concurrent_pop();
        idle();
        bus.hold = 1'b1;
        for (int i = 0; i < DEPTH; i++) push_now(AW'($urandom), DW'($urandom));
        bus.hold     = 1'b0;
        bus.in_valid = 1'b1;
        bus.in_reg   = AW'(7);
        bus.in_data  = 16'hBEEF;
        #1;
        checks++;
        if (bus.in_ready !== 1'b0 || bus.write !== 1'b1) begin
            errors++;
            $display("FAIL full_pop actual in_ready=%b write=%b required 0 1", bus.in_ready, bus.write);
        end
        advance();
        checks++;
        if (bus.count !== CW'(3) || bus.in_ready !== 1'b1) begin
            errors++;
            $display("FAIL full_after actual count=%0d in_ready=%b required 3 1", bus.count, bus.in_ready);
        end
        advance();
        checks++;
        if (bus.count !== CW'(3) || bus.busy !== exp_busy()) begin
            errors++;
            $display("FAIL push_pop_count actual count=%0d busy=%h required 3 %h", bus.count, bus.busy, exp_busy());
        end
        drain();
    endtask

    task automatic test_flush();
        int wr_before;
        idle();
        bus.hold = 1'b1;
        push_now(AW'(4), DW'($urandom));
        push_now(AW'(5), DW'($urandom));
        push_now(AW'(6), DW'($urandom));
        bus.hold     = 1'b0;
        bus.flush    = 1'b1;
        bus.in_valid = 1'b1;
        bus.in_reg   = AW'(1);
        bus.in_data  = 16'hDEAD;
        #1;
        checks++;
        if (bus.write !== 1'b0 || bus.in_ready !== 1'b0) begin
            errors++;
            $display("FAIL flush_cycle actual write=%b in_ready=%b required 0 0", bus.write, bus.in_ready);
        end
        wr_before = dut_wr;
        advance();
        idle();
        bus.fwd_num = AW'(4);
        #1;
        checks++;
        if (bus.count !== CW'(0) || bus.busy !== NR'(0) || bus.fwd_hit !== 1'b0) begin
            errors++;
            $display("FAIL flush_after actual count=%0d busy=%h fwd_hit=%b required 0 00 0",
                     bus.count, bus.busy, bus.fwd_hit);
        end
        advance();
        advance();
        checks++;
        if (dut_wr !== wr_before) begin
            errors++;
            $display("FAIL flush_nowrite actual writes=%0d required %0d", dut_wr, wr_before);
        end
    endtask

    task automatic test_random();
        for (int c = 0; c < 500; c++) begin
            bus.in_valid = ($urandom_range(0, 3) != 0);
            bus.in_reg   = AW'($urandom);
            bus.in_data  = DW'($urandom);
            bus.hold     = ($urandom_range(0, 3) == 0);
            bus.flush    = ($urandom_range(0, 24) == 0);
            bus.fwd_num  = AW'($urandom);
            #1;
            checks++;
            if (bus.in_ready !== ((mq.size() != DEPTH) && !bus.flush) ||
                bus.write !== ((mq.size() != 0) && !bus.hold && !bus.flush) ||
                bus.count !== CW'(mq.size()) || bus.busy !== exp_busy() ||
                bus.fwd_hit !== exp_hit(bus.fwd_num) || bus.fwd_data !== exp_fwd(bus.fwd_num)) begin
                errors++;
                $display("FAIL rand_cycle%0d actual rdy=%b wr=%b cnt=%0d busy=%h hit=%b fd=%h required cnt=%0d busy=%h hit=%b fd=%h",
                         c, bus.in_ready, bus.write, bus.count, bus.busy, bus.fwd_hit, bus.fwd_data,
                         mq.size(), exp_busy(), exp_hit(bus.fwd_num), exp_fwd(bus.fwd_num));
            end
            if (bus.write === 1'b1 && mq.size() != 0) begin
                checks++;
                if (bus.writenum !== mq[0].r || bus.data_in !== mq[0].d) begin
                    errors++;
                    $display("FAIL rand_head%0d actual num=%0d data=%h required %0d %h",
                             c, bus.writenum, bus.data_in, mq[0].r, mq[0].d);
                end
            end
            advance();
        end
        drain();
    endtask

    initial begin
        for (int i = 0; i < NR; i++) begin
            rf_ref[i] = '0;
            rf_dut[i] = '0;
        end
        test_reset();
        test_single_push();
        test_fill_hold();
        test_same_reg_fwd();
        test_full_concurrent_pop();
        test_flush();
        test_random();
        for (int i = 0; i < NR; i++) begin
            checks++;
            if (rf_dut[i] !== rf_ref[i]) begin
                errors++;
                $display("FAIL regfile_R%0d actual=%h required=%h", i, rf_dut[i], rf_ref[i]);
            end
        end
        checks++;
        if (dut_wr !== ref_wr) begin
            errors++;
            $display("FAIL write_total actual=%0d required=%0d", dut_wr, ref_wr);
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/wb_write_queue.md
Name: wb_write_queue

Overview:
Write-side companion to the 8x16 register file. It buffers writeback results (destination register number + data) from the pipeline's writeback stage in a small in-order FIFO. It drains one entry per cycle into the register file's single write port (write/writenum/data_in). It also exports a pending-write scoreboard and a youngest-match forwarding path, so the decode stage can stall or bypass on registers that are queued but not yet written.

Parameters:
DEPTH, 4, number of queue entries (power of two, >=2)
DW, 16, data width; matches register width
AW, 3, register-number width (8 registers)

Ports:
clk  input  1  rising-edge clock shared with the register file
rst_n  input  1  asynchronous active-low reset
in_valid  input  1  writeback result offered this cycle
in_ready  output  1  queue can accept this cycle
in_reg  input  AW  destination register number
in_data  input  DW  result value
hold  input  1  suppress draining this cycle (e.g. register file read-priority window)
flush  input  1  synchronous discard of all queued entries
write  output  1  register-file write enable
writenum  output  AW  register-file write address (queue head reg)
data_in  output  DW  register-file write data (queue head data)
busy  output  2**AW  bit r set iff any valid queued entry targets register r
fwd_num  input  AW  register number being looked up by decode
fwd_hit  output  1  some valid entry targets fwd_num
fwd_data  output  DW  data of the youngest valid entry targeting fwd_num; 0 when no hit
count  output  $clog2(DEPTH)+1  number of valid entries

Behaviour:
- Storage is a circular buffer: DEPTH x {AW reg, DW data}, with rd_ptr, wr_ptr and count registers. Pointers wrap modulo DEPTH.
- Reset (rst_n low, asynchronous): count=0, rd_ptr=wr_ptr=0, all entry-valid bits cleared. Outputs: write=0, busy=0, fwd_hit=0, fwd_data=0, in_ready=1. Entry payload RAM is not reset.
- in_ready = (count != DEPTH) && !flush. This is combinational and does not depend on a same-cycle pop: a full queue refuses input even while draining.
- Push: on an edge with in_valid && in_ready, write {in_reg,in_data} at wr_ptr, then wr_ptr+1.
- Drain (combinational outputs from the head):
  - write = (count != 0) && !hold && !flush.
  - writenum and data_in = head entry. When write=0 they still show the head entry (don't-care).
  - Pop occurs on the same edge the register file captures, i.e. any edge with write=1; rd_ptr then advances by 1.
- Latency: an entry pushed at edge N is presented with write=1 during the cycle after edge N at the earliest, and lands in the register file at edge N+1. There is no same-cycle bypass from in_* to write.
- Simultaneous push and pop: count unchanged; both pointers advance.
- Order: strictly FIFO. Two entries to the same register are written oldest first, so the youngest value wins in the register file.
- flush: at the next edge count=0, rd_ptr=wr_ptr, valid bits cleared. No write occurs in the flush cycle and any offered push is dropped (in_ready=0).
- hold with full queue: in_ready=0, write=0, and state holds.
- busy: combinational OR of one-hot(entry.reg) over valid entries. A register being popped in the current cycle still shows busy in that cycle and clears after the edge.
- Forwarding: fwd_hit/fwd_data are combinational. On multiple matches, the entry closest to wr_ptr (the youngest) is selected. Incoming in_* is not searched.
- count never exceeds DEPTH and never underflows; pushes when full and pops when empty are impossible by construction.

Test Plan:
- Reset then idle: rst_n low mid-stream with 3 entries queued -> write=0, busy=0, count=0, in_ready=1 immediately, without waiting for a clock edge.
- Single push: push R3=0x00A5 at edge 1 -> cycle after: write=1, writenum=3, data_in=0x00A5, busy=0x08. After edge 2: count=0, busy=0, R3 in the regfile model reads 0x00A5.
- Fill with hold=1: push R1..R4 = 0x0011..0x0044 -> count=4, in_ready=0, busy=0x1E. A fifth offer (R5) is not accepted. Release hold -> writes appear in order R1,R2,R3,R4 on 4 consecutive cycles.
- Same-register forwarding: hold=1, push R2=0x1111 then R2=0x2222, fwd_num=2 -> fwd_hit=1, fwd_data=0x2222, busy=0x04. Release hold -> final regfile R2=0x2222.
- Full with concurrent pop: queue full, hold=0, in_valid=1 -> in_ready=0 and no push that cycle. Next cycle count=3 and in_ready=1; then push+pop together -> count stays 3.
- Flush: 3 entries queued, flush=1 with in_valid=1 -> write=0 and in_ready=0 that cycle. After the edge: count=0, busy=0, fwd_hit=0, and no regfile write for any flushed entry.
